ski_term_stream_unbinarize: RTL and testbench



---
 rtl/ski_term_pkg.sv | 61 ++++++
 rtl/ski_beat_collector.sv | 96 +++++++++
 rtl/ski_term_stream_unbinarize.sv | 80 ++++++++
 tb/tb_ski_term_stream_unbinarize.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ski_term_pkg.sv
// Shared SKI term definitions: tag codes, width helpers and the pure word decoder.
package ski_term_pkg;

  localparam logic [3:0] TAG_S   = 4'd0;
  localparam logic [3:0] TAG_K   = 4'd1;
  localparam logic [3:0] TAG_I   = 4'd2;
  localparam logic [3:0] TAG_APP = 4'd3;
  localparam logic [3:0] TAG_LIT = 4'd4;

  // Decoder payload is sized for the widest supported heap pointer.
  localparam int unsigned MAX_PTR_W = 32;
  localparam int unsigned PAY_MAX_W = 2 * MAX_PTR_W;

  // Beat collector states.
  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

  typedef struct packed {
    logic                 tagOk;
    logic [2:0]           tag;
    logic [PAY_MAX_W-1:0] payload;
  } termDecodeT;

  function automatic int unsigned WORD_W(input int unsigned ptrW);
    return 4 + 2 * ptrW;
  endfunction

  function automatic int unsigned TERM_W(input int unsigned ptrW);
    return 3 + 2 * ptrW;
  endfunction

  // Word payload (low 2*ptrW bits, zero-extended) plus 4-bit tag -> tagged term.
  function automatic termDecodeT decodeTerm(input logic [3:0]           tag,
                                            input logic [PAY_MAX_W-1:0] payload,
                                            input int unsigned          ptrW,
                                            input int unsigned          litW);
    termDecodeT           res;
    logic [PAY_MAX_W-1:0] litMask;
    res     = '0;
    litMask = (PAY_MAX_W'(1) << litW) - PAY_MAX_W'(1);
    case (tag)
      TAG_S, TAG_K, TAG_I: begin
        res.tagOk = 1'b1;
        res.tag   = tag[2:0];
      end
      TAG_APP: begin
        res.tagOk   = 1'b1;
        res.tag     = tag[2:0];
        res.payload = payload;
      end
      TAG_LIT: begin
        res.tagOk   = 1'b1;
        res.tag     = tag[2:0];
        res.payload = (payload & litMask) << (2 * ptrW - litW);
      end
      default: res.tagOk = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ski_beat_collector.sv
// Reassembles BEATS narrow beats into one heap word; holds a finished word
// until the consumer side agrees to take it.
module ski_beat_collector
  import ski_term_pkg::*;
#(
  parameter int unsigned BUS_W = 16,
  parameter int unsigned BEATS = 4
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [BUS_W-1:0]       beat,
  input  logic                   beatValid,
  output logic                   beatReady,
  input  logic                   take_c,
  output logic [BUS_W*BEATS-1:0] word_c,
  output logic                   wordDone_c
);

  localparam int unsigned     wordW   = BUS_W * BEATS;
  localparam int unsigned     cntW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [cntW-1:0] lastCnt = cntW'(BEATS - 1);

  logic [0:0]      state;
  logic [0:0]      stateNext;
  logic [cntW-1:0] cnt;
  logic [cntW-1:0] cntNext;
  logic [wordW-1:0] asm;
  logic            beatAcc;

  assign beatAcc = beatValid && beatReady;

  // State, beat counter and ready flag registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state     <= ST_COLLECT;
      cnt       <= '0;
      beatReady <= 1'b1;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      beatReady <= (stateNext == ST_COLLECT);
    end
  end

  // Beat k lands in slot k; the final beat is also stored so HOLD has the full word.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      asm <= '0;
    end else begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (beatAcc && (cnt == cntW'(k))) begin
          asm[k*BUS_W +: BUS_W] <= beat;
        end
      end
    end
  end

  // Word presented to the decoder: live final beat in COLLECT, stored word in HOLD.
  always_comb begin
    word_c = asm;
    if (state == ST_COLLECT) begin
      word_c[(BEATS-1)*BUS_W +: BUS_W] = beat;
    end
  end

  // Next-state logic: finish a word now if it can be taken, otherwise park in HOLD.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    wordDone_c = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (beatAcc) begin
          if (cnt == lastCnt) begin
            cntNext = '0;
            if (take_c) begin
              wordDone_c = 1'b1;
            end else begin
              stateNext = ST_HOLD;
            end
          end else begin
            cntNext = cnt + cntW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (take_c) begin
          wordDone_c = 1'b1;
          stateNext  = ST_COLLECT;
        end
      end
      default: stateNext = ST_COLLECT;
    endcase
  end

endmodule

// File: rtl/ski_term_stream_unbinarize.sv
// Streaming SKI term unbinarizer: beats in, decoded term out on a registered
// valid/ready slot; words with undefined tags are dropped and counted.
module ski_term_stream_unbinarize
  import ski_term_pkg::*;
#(
  parameter int unsigned PTR_W = 30,
  parameter int unsigned LIT_W = 32,
  parameter int unsigned BUS_W = 16
) (
  input  logic                      system1000,
  input  logic                      system1000_rstn,
  input  logic [BUS_W-1:0]          beat_i,
  input  logic                      beat_valid_i,
  output logic                      beat_ready_o,
  output logic [TERM_W(PTR_W)-1:0]  term_o,
  output logic                      term_valid_o,
  input  logic                      term_ready_i,
  output logic                      err_o,
  output logic [7:0]                err_cnt_o
);

  localparam int unsigned wordW = WORD_W(PTR_W);
  localparam int unsigned payW  = 2 * PTR_W;
  localparam int unsigned beats = wordW / BUS_W;

  logic [wordW-1:0] word_c;
  logic             wordDone_c;
  logic             slotFree_c;
  logic             take_c;
  logic             load_c;
  logic             drop_c;
  termDecodeT       dec_c;

  ski_beat_collector #(
    .BUS_W(BUS_W),
    .BEATS(beats)
  ) uCollector (
    .clk        (system1000),
    .rstN       (system1000_rstn),
    .beat       (beat_i),
    .beatValid  (beat_valid_i),
    .beatReady  (beat_ready_o),
    .take_c     (take_c),
    .word_c     (word_c),
    .wordDone_c (wordDone_c)
  );

  // Decode the word currently offered by the collector.
  always_comb begin
    dec_c = decodeTerm(word_c[wordW-1 -: 4], PAY_MAX_W'(word_c[payW-1:0]), PTR_W, LIT_W);
  end

  // Undefined-tag words never need the output slot, so they are always taken.
  assign slotFree_c = !term_valid_o || term_ready_i;
  assign take_c     = slotFree_c || !dec_c.tagOk;
  assign load_c     = wordDone_c && dec_c.tagOk;
  assign drop_c     = wordDone_c && !dec_c.tagOk;

  // Output term slot, drop pulse and saturating drop counter.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      term_o       <= '0;
      term_valid_o <= 1'b0;
      err_o        <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      err_o <= drop_c;
      if (drop_c && (err_cnt_o != 8'hFF)) begin
        err_cnt_o <= err_cnt_o + 8'd1;
      end
      if (load_c) begin
        term_o       <= {dec_c.tag, payW'(dec_c.payload)};
        term_valid_o <= 1'b1;
      end else if (term_ready_i) begin
        term_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ski_term_stream_unbinarize.sv
// Self-checking bench for ski_term_stream_unbinarize at default parameters.
module tb_ski_term_stream_unbinarize;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] beatIn = '0;
  logic        beatValid = 1'b0;
  logic        beatReady;
  logic [62:0] term;
  logic        termValid;
  logic        termReady = 1'b0;
  logic        err;
  logic [7:0]  errCnt;

  int          nChecks = 0;
  int          nFails = 0;
  int unsigned cyc = 0;
  logic [62:0] gotQ[$];
  int          errPulses = 0;

  ski_term_stream_unbinarize dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .beat_i          (beatIn),
    .beat_valid_i    (beatValid),
    .beat_ready_o    (beatReady),
    .term_o          (term),
    .term_valid_o    (termValid),
    .term_ready_i    (termReady),
    .err_o           (err),
    .err_cnt_o       (errCnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every term handshake and every drop pulse (inputs are stable at negedge).
  always @(negedge clk) begin
    if (rstn && termValid && termReady) gotQ.push_back(term);
    if (rstn && err) errPulses <= errPulses + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expectEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the tag rules, on whole 64-bit words.
  function automatic logic [62:0] refTerm(input logic [63:0] w, output bit ok);
    logic [63:0] t;
    logic [63:0] r;
    t  = w >> 60;
    ok = (t <= 64'd4);
    if (t <= 64'd2)       r = t << 60;
    else if (t == 64'd3)  r = (64'd3 << 60) | (w & ((64'd1 << 60) - 64'd1));
    else if (t == 64'd4)  r = (64'd4 << 60) | ((w & 64'hFFFF_FFFF) << 28);
    else                  r = '0;
    return r[62:0];
  endfunction

  task automatic idle(input int n);
    beatValid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendBeat(input logic [15:0] b);
    int   n;
    logic acc;
    n         = 0;
    acc       = 1'b0;
    beatIn    = b;
    beatValid = 1'b1;
    do begin
      @(negedge clk);
      acc = beatReady;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    beatValid = 1'b0;
    expectEq("beat_accept", 64'(acc), 64'd1);
  endtask

  task automatic sendWord(input logic [63:0] w, input int maxGap);
    for (int k = 0; k < 4; k++) begin
      if (maxGap > 0) idle($urandom_range(0, maxGap));
      sendBeat(w[k*16 +: 16]);
    end
  endtask

  logic [62:0] expQ[$];
  int          base;
  int          errBase;
  int          expErr;
  int unsigned t0;
  bit          sendDone;
  bit          ok;
  logic [62:0] exp;

  initial begin
    // Reset values
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expectEq("rst_term_valid", 64'(termValid), 64'd0);
    expectEq("rst_term", 64'(term), 64'd0);
    expectEq("rst_err", 64'(err), 64'd0);
    expectEq("rst_err_cnt", 64'(errCnt), 64'd0);
    expectEq("rst_beat_ready", 64'(beatReady), 64'd1);
    rstn      = 1'b1;
    termReady = 1'b1;
    idle(1);

    // Application term, one cycle after the 4th beat
    sendWord(64'h3000_0001_4000_0007, 0);
    expectEq("app_valid", 64'(termValid), 64'd1);
    expectEq("app_term", 64'(term), 64'({3'b011, 30'd5, 30'd7}));
    idle(1);
    expectEq("app_drained", 64'(termValid), 64'd0);

    // Back-to-back words with ready high: no bubble
    t0 = cyc;
    sendWord(64'h3000_0000_4000_0002, 0);
    sendWord(64'h3000_0000_C000_0004, 0);
    expectEq("throughput_cycles", 64'(cyc - t0), 64'd8);
    expectEq("throughput_term", 64'(term), 64'({3'b011, 30'd3, 30'd4}));
    idle(1);

    // Literal
    sendWord(64'h4000_0000_DEAD_BEEF, 0);
    expectEq("lit_term", 64'(term), 64'({3'b100, 32'hDEADBEEF, 28'b0}));
    idle(1);

    // Tag with ignored payload
    sendWord(64'h1FFF_FFFF_FFFF_FFFF, 0);
    expectEq("k_valid", 64'(termValid), 64'd1);
    expectEq("k_term", 64'(term), 64'({3'b001, 60'b0}));
    idle(1);

    // Undefined tag: dropped, one-cycle pulse, counted
    sendWord(64'h7000_0000_0000_0000, 0);
    expectEq("undef_valid", 64'(termValid), 64'd0);
    expectEq("undef_err", 64'(err), 64'd1);
    expectEq("undef_err_cnt", 64'(errCnt), 64'd1);
    idle(1);
    expectEq("undef_err_pulse_end", 64'(err), 64'd0);
    repeat (299) sendWord(64'h7000_0000_0000_0000, 0);
    idle(1);
    expectEq("undef_err_sat", 64'(errCnt), 64'd255);

    // Backpressure: second word parks in HOLD until the slot frees
    termReady = 1'b0;
    base      = gotQ.size();
    sendWord(64'h3000_0000_4000_0002, 0);
    sendWord(64'h3000_0000_C000_0004, 0);
    expectEq("bp_hold_ready", 64'(beatReady), 64'd0);
    expectEq("bp_first_term", 64'(term), 64'({3'b011, 30'd1, 30'd2}));
    idle(2);
    expectEq("bp_still_hold", 64'(beatReady), 64'd0);
    termReady = 1'b1;
    idle(1);
    expectEq("bp_second_term", 64'(term), 64'({3'b011, 30'd3, 30'd4}));
    expectEq("bp_second_valid", 64'(termValid), 64'd1);
    expectEq("bp_ready_back", 64'(beatReady), 64'd1);
    idle(1);
    expectEq("bp_drained", 64'(termValid), 64'd0);
    expectEq("bp_count", 64'(gotQ.size() - base), 64'd2);
    if (gotQ.size() - base == 2) begin
      expectEq("bp_order0", 64'(gotQ[base]), 64'({3'b011, 30'd1, 30'd2}));
      expectEq("bp_order1", 64'(gotQ[base+1]), 64'({3'b011, 30'd3, 30'd4}));
    end

    // Reset mid-word discards the partial word
    base    = gotQ.size();
    errBase = errPulses;
    sendBeat(16'hBEEF);
    sendBeat(16'hDEAD);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    expectEq("midrst_err_cnt", 64'(errCnt), 64'd0);
    sendWord(64'h4000_0000_DEAD_BEEF, 0);
    expectEq("midrst_term", 64'(term), 64'({3'b100, 32'hDEADBEEF, 28'b0}));
    idle(3);
    expectEq("midrst_one_term", 64'(gotQ.size() - base), 64'd1);
    expectEq("midrst_no_err", 64'(errPulses - errBase), 64'd0);

    // Randomized words, gaps and backpressure against the reference decode
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn     = 1'b1;
    base     = gotQ.size();
    errBase  = errPulses;
    expErr   = 0;
    sendDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [3:0]  tg;
          logic [63:0] w;
          if ($urandom_range(0, 3) == 0) tg = 4'($urandom_range(5, 15));
          else                           tg = 4'($urandom_range(0, 4));
          w   = {tg, 60'({$urandom, $urandom})};
          exp = refTerm(w, ok);
          if (ok) expQ.push_back(exp);
          else    expErr++;
          sendWord(w, 2);
        end
        sendDone = 1'b1;
      end
      begin
        while (!sendDone) begin
          @(posedge clk);
          #1;
          termReady = ($urandom_range(0, 2) != 0);
        end
      end
    join
    termReady = 1'b1;
    idle(10);
    expectEq("rand_count", 64'(gotQ.size() - base), 64'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (base + i < gotQ.size()) expectEq("rand_term", 64'(gotQ[base+i]), 64'(expQ[i]));
    end
    expectEq("rand_err_pulses", 64'(errPulses - errBase), 64'(expErr));
    expectEq("rand_err_cnt", 64'(errCnt), 64'(expErr));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
